// File: rtl/trace_align_monitor_pkg.sv
// Shared types and width helpers for the trace alignment monitor.
package trace_align_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MISMATCH = 2'd2,
        OVERFLOW = 2'd3
    } state_t;

    localparam int unsigned DEF_DEPTH = 4;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Counts must hold 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/trace_align_monitor_fifo.sv
// Single-clock alignment FIFO; head is the registered oldest entry.
module align_fifo
    import trace_align_monitor_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = DEF_DEPTH,
    localparam int PW = ptr_w(DEPTH),
    localparam int CW = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // A push into a full FIFO with a pop overwrites the slot being read out.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/trace_align_monitor.sv
// Aligns source/target traces by dropping stutter steps and
// compares the remaining public outputs in order.
module trace_align_monitor
    import trace_align_monitor_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = 8,
    localparam int LW = $clog2(DEPTH) + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [WIDTH-1:0]     pub_src,
    input  logic                 st_src,
    input  logic [WIDTH-1:0]     pub_tar,
    input  logic                 st_tar,
    output logic                 mismatch,
    output logic                 overflow,
    output logic                 aligned,
    output logic signed [LW-1:0] lag,
    output logic [CNT_W-1:0]     match_cnt,
    output logic [WIDTH-1:0]     bad_src,
    output logic [WIDTH-1:0]     bad_tar
);

    localparam int FCW = cnt_w(DEPTH);

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] head_src;
    logic [WIDTH-1:0] head_tar;
    logic [FCW-1:0]   cnt_src;
    logic [FCW-1:0]   cnt_tar;
    logic             full_src;
    logic             full_tar;
    logic             empty_src;
    logic             empty_tar;

    logic live;
    logic req_src;
    logic req_tar;
    logic cmp;
    logic eq;
    logic ovf_src;
    logic ovf_tar;
    logic mis_ev;
    logic ovf_ev;
    logic push_src;
    logic push_tar;

    assign live    = (state == IDLE) || (state == RUN);
    assign req_src = live && en && !st_src;
    assign req_tar = live && en && !st_tar;

    // Compare only registered heads, so a value never meets itself
    // on its own push edge.
    assign cmp    = (state == RUN) && !empty_src && !empty_tar;
    assign eq     = (head_src == head_tar);
    assign mis_ev = cmp && !eq;

    assign ovf_src  = req_src && full_src && !cmp;
    assign ovf_tar  = req_tar && full_tar && !cmp;
    assign ovf_ev   = ovf_src || ovf_tar;
    assign push_src = req_src && !ovf_src;
    assign push_tar = req_tar && !ovf_tar;

    align_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_src (
        .clk   (clk),
        .rst   (rst),
        .push  (push_src),
        .pop   (cmp),
        .din   (pub_src),
        .head  (head_src),
        .count (cnt_src),
        .full  (full_src),
        .empty (empty_src)
    );

    align_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tar (
        .clk   (clk),
        .rst   (rst),
        .push  (push_tar),
        .pop   (cmp),
        .din   (pub_tar),
        .head  (head_tar),
        .count (cnt_tar),
        .full  (full_tar),
        .empty (empty_tar)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (en) state_nx = RUN;
            RUN: begin
                if (mis_ev)      state_nx = MISMATCH;
                else if (ovf_ev) state_nx = OVERFLOW;
            end
            default:  state_nx = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch  <= 1'b0;
            overflow  <= 1'b0;
            match_cnt <= '0;
            bad_src   <= '0;
            bad_tar   <= '0;
        end else begin
            if (mis_ev) begin
                mismatch <= 1'b1;
                bad_src  <= head_src;
                bad_tar  <= head_tar;
            end
            if (ovf_ev) overflow <= 1'b1;
            if (cmp && eq && (match_cnt != '1)) begin
                match_cnt <= match_cnt + 1'b1;
            end
        end
    end

    assign lag     = $signed({1'b0, cnt_src}) - $signed({1'b0, cnt_tar});
    assign aligned = live && empty_src && empty_tar;

endmodule

// File: tb/tb_trace_align_monitor.sv
// Table vectors plus randomized traffic against a queue-based model.
module tb_trace_align_monitor;

    localparam int WIDTH = 2;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int LW    = $clog2(DEPTH) + 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic [WIDTH-1:0]     pub_src;
    logic                 st_src;
    logic [WIDTH-1:0]     pub_tar;
    logic                 st_tar;
    logic                 mismatch;
    logic                 overflow;
    logic                 aligned;
    logic signed [LW-1:0] lag;
    logic [CNT_W-1:0]     match_cnt;
    logic [WIDTH-1:0]     bad_src;
    logic [WIDTH-1:0]     bad_tar;

    int errors = 0;
    int checks = 0;

    trace_align_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .pub_src   (pub_src),
        .st_src    (st_src),
        .pub_tar   (pub_tar),
        .st_tar    (st_tar),
        .mismatch  (mismatch),
        .overflow  (overflow),
        .aligned   (aligned),
        .lag       (lag),
        .match_cnt (match_cnt),
        .bad_src   (bad_src),
        .bad_tar   (bad_tar)
    );

    always #5 clk = ~clk;

    // Reference model: two plain queues and a few flags.
    logic [WIDTH-1:0] qs[$];
    logic [WIDTH-1:0] qt[$];
    bit               m_started;
    bit               m_mis;
    bit               m_ovf;
    int               m_match;
    int               m_bs;
    int               m_bt;

    task automatic model_edge();
        bit               do_cmp;
        logic [WIDTH-1:0] hs;
        logic [WIDTH-1:0] ht;
        if (rst) begin
            qs.delete();
            qt.delete();
            m_started = 0;
            m_mis     = 0;
            m_ovf     = 0;
            m_match   = 0;
            m_bs      = 0;
            m_bt      = 0;
        end else if (!m_mis && !m_ovf) begin
            do_cmp = m_started && qs.size() > 0 && qt.size() > 0;
            if (do_cmp) begin
                hs = qs.pop_front();
                ht = qt.pop_front();
                if (hs == ht) begin
                    if (m_match < (1 << CNT_W) - 1) m_match++;
                end else begin
                    m_mis = 1;
                    m_bs  = int'(hs);
                    m_bt  = int'(ht);
                end
            end
            if (en && !st_src) begin
                if (qs.size() < DEPTH) qs.push_back(pub_src);
                else m_ovf = 1;
            end
            if (en && !st_tar) begin
                if (qt.size() < DEPTH) qt.push_back(pub_tar);
                else m_ovf = 1;
            end
            if (en) m_started = 1;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int al;
        al = (qs.size() == 0 && qt.size() == 0 && !m_mis && !m_ovf) ? 1 : 0;
        chk("mdl_mismatch", int'(mismatch), int'(m_mis));
        chk("mdl_overflow", int'(overflow), int'(m_ovf));
        chk("mdl_aligned", int'(aligned), al);
        chk("mdl_lag", int'(lag), qs.size() - qt.size());
        chk("mdl_match_cnt", int'(match_cnt), m_match);
        chk("mdl_bad_src", int'(bad_src), m_bs);
        chk("mdl_bad_tar", int'(bad_tar), m_bt);
    endtask

    task automatic step(input logic r, input logic e,
                        input logic [WIDTH-1:0] ps, input logic ss,
                        input logic [WIDTH-1:0] pt, input logic stt);
        @(negedge clk);
        rst     = r;
        en      = e;
        pub_src = ps;
        st_src  = ss;
        pub_tar = pt;
        st_tar  = stt;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic             rst;
        logic             en;
        logic [WIDTH-1:0] ps;
        logic             ss;
        logic [WIDTH-1:0] pt;
        logic             stt;
        logic             e_mis;
        logic             e_ovf;
        logic             e_al;
        int               e_lag;
        int               e_m;
        int               e_bs;
        int               e_bt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic e,
                                input int ps, input logic ss,
                                input int pt, input logic stt,
                                input logic mi, input logic ov,
                                input logic al, input int lg,
                                input int m, input int bs = 0,
                                input int bt = 0);
        vec_t v;
        v.rst   = r;
        v.en    = e;
        v.ps    = WIDTH'(ps);
        v.ss    = ss;
        v.pt    = WIDTH'(pt);
        v.stt   = stt;
        v.e_mis = mi;
        v.e_ovf = ov;
        v.e_al  = al;
        v.e_lag = lg;
        v.e_m   = m;
        v.e_bs  = bs;
        v.e_bt  = bt;
        return v;
    endfunction

    initial begin
        logic [WIDTH-1:0] gen[$];
        int               p_ss;
        int               p_st;
        logic             r;
        logic             e;
        logic             ss;
        logic             stt;
        logic [WIDTH-1:0] ps;
        logic [WIDTH-1:0] pt;

        rst = 1'b1;
        en = 1'b0;
        pub_src = '0;
        st_src = 1'b0;
        pub_tar = '0;
        st_tar = 1'b0;

        // lockstep 1,2,3,0
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2, 0, 2, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 3, 0, 3, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4));
        // source stutters
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 0, 0, -1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 2, 0, 0, 0, 0, -1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 0, -1, 1));
        tbl.push_back(mk(0, 1, 2, 0, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2));
        // divergence
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 2, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 3, 2));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 3, 2));
        // overflow
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 2, 0, 0, 1, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0, 1, 3, 0, 0, 1, 0, 0, 0, 3, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 4, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 1, 0, 4, 0));
        tbl.push_back(mk(0, 1, 2, 0, 3, 0, 0, 1, 0, 4, 0));
        // full with simultaneous pop, then reset mid-operation
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 2, 0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0, 1, 3, 0, 0, 1, 0, 0, 0, 3, 0));
        tbl.push_back(mk(0, 1, 0, 0, 2, 0, 0, 0, 0, 3, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 4, 1));
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 3, 1));
        tbl.push_back(mk(1, 1, 3, 0, 3, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].ps, tbl[i].ss,
                 tbl[i].pt, tbl[i].stt);
            chk($sformatf("v%0d_mismatch", i), int'(mismatch),
                int'(tbl[i].e_mis));
            chk($sformatf("v%0d_overflow", i), int'(overflow),
                int'(tbl[i].e_ovf));
            chk($sformatf("v%0d_aligned", i), int'(aligned),
                int'(tbl[i].e_al));
            chk($sformatf("v%0d_lag", i), int'(lag), tbl[i].e_lag);
            chk($sformatf("v%0d_match_cnt", i), int'(match_cnt),
                tbl[i].e_m);
            chk($sformatf("v%0d_bad_src", i), int'(bad_src), tbl[i].e_bs);
            chk($sformatf("v%0d_bad_tar", i), int'(bad_tar), tbl[i].e_bt);
            check_model();
        end

        // Random traffic; target mostly replays the source stream.
        p_ss = 2;
        p_st = 2;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) begin
                p_ss = $urandom_range(0, 6);
                p_st = $urandom_range(0, 6);
            end
            r   = ($urandom_range(0, 47) == 0);
            e   = ($urandom_range(0, 3) != 0);
            ss  = ($urandom_range(0, 7) < p_ss);
            stt = ($urandom_range(0, 7) < p_st);
            ps  = WIDTH'($urandom);
            pt  = WIDTH'($urandom);
            if (!stt && e && gen.size() > 0 && $urandom_range(0, 31) != 0)
                pt = gen.pop_front();
            if (!ss && e && gen.size() < 16) gen.push_back(ps);
            if (r) gen.delete();
            step(r, e, ps, ss, pt, stt);
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
